// File: rtl/bias_act.sv
// Bias-add + saturate + optional ReLU stage behind a 4-slot input FIFO.
// Define BIAS_ACT_RELU_EN to clamp negative results to zero in the output stage.
module bias_act #(
    parameter int DATA_WIDTH    = 8,
    parameter int GROUP_SIZE    = 4,
    parameter int LOG_MAX_ITEMS = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             configure,
    input  logic [LOG_MAX_ITEMS-1:0]         num_items,
    input  logic [GROUP_SIZE*DATA_WIDTH-1:0] bias,
    input  logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in,
    input  logic                             valid_in,
    output logic                             avail_out,
    output logic [GROUP_SIZE*DATA_WIDTH-1:0] data_out,
    output logic                             valid_out,
    input  logic                             avail_in,
    output logic                             done
);
    localparam int WORD_W = GROUP_SIZE * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [LOG_MAX_ITEMS-1:0] CNT_ONE = LOG_MAX_ITEMS'(1);
    localparam logic [LOG_MAX_ITEMS-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [LOG_MAX_ITEMS-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0]        bias_q, bias_d;
    logic [WORD_W-1:0]        mem_q [4];
    logic [WORD_W-1:0]        mem_d [4];
    logic [1:0]               wr_ptr_q, wr_ptr_d;
    logic [1:0]               rd_ptr_q, rd_ptr_d;
    logic [2:0]               count_q, count_d;
    logic                     s1_v_q, s1_v_d;
    logic                     s2_v_q, s2_v_d;
    logic [WORD_W-1:0]        s1_data_q, s1_data_d;
    logic [WORD_W-1:0]        s2_data_q, s2_data_d;
    logic                     done_q, done_d;

    logic                     full, almost_full, empty;
    logic                     wr_en, issue;
    logic [WORD_W-1:0]        fifo_head;
    logic signed [DATA_WIDTH:0] sum [GROUP_SIZE];

    assign full        = (count_q == 3'd4);
    assign almost_full = (count_q == 3'd3);
    assign empty       = (count_q == 3'd0);
    assign wr_en       = valid_in & ~full;
    assign issue       = (state_q == RUN) & ~empty & avail_in;
    assign fifo_head   = mem_q[rd_ptr_q];

    assign avail_out = ~full & ~almost_full;
    assign data_out  = s2_data_q;
    assign valid_out = s2_v_q;
    assign done      = done_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d = count_q + 3'(wr_en) - 3'(issue);
    end

    // A configure pulse overrides whatever the current state would do, but the
    // FIFO and pipeline are left alone so in-flight words still drain out.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bias_d  = bias_q;
        done_d  = 1'b0;
        case (state_q)
            RUN: begin
                if (issue) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!s1_v_q && !s2_v_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
        if (configure) begin
            cnt_d   = num_items;
            bias_d  = bias;
            state_d = (num_items == CNT_ZERO) ? DRAIN : RUN;
            done_d  = 1'b0;
        end
    end

    // Stage 1: widen by one bit, add, then clamp when the two top bits disagree.
    always_comb begin
        s1_v_d    = issue;
        s1_data_d = s1_data_q;
        for (int i = 0; i < GROUP_SIZE; i++) begin
            sum[i] = $signed({fifo_head[i*DATA_WIDTH+DATA_WIDTH-1], fifo_head[i*DATA_WIDTH +: DATA_WIDTH]})
                   + $signed({bias_q[i*DATA_WIDTH+DATA_WIDTH-1], bias_q[i*DATA_WIDTH +: DATA_WIDTH]});
            if (issue) begin
                if (sum[i][DATA_WIDTH] != sum[i][DATA_WIDTH-1]) begin
                    s1_data_d[i*DATA_WIDTH +: DATA_WIDTH] = sum[i][DATA_WIDTH] ? SAT_MIN : SAT_MAX;
                end else begin
                    s1_data_d[i*DATA_WIDTH +: DATA_WIDTH] = sum[i][DATA_WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        s2_v_d    = s1_v_q;
        s2_data_d = s2_data_q;
        if (s1_v_q) begin
            s2_data_d = s1_data_q;
`ifdef BIAS_ACT_RELU_EN
            for (int i = 0; i < GROUP_SIZE; i++) begin
                if (s1_data_q[i*DATA_WIDTH+DATA_WIDTH-1]) begin
                    s2_data_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bias_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s1_data_q <= '0;
            s2_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bias_q    <= bias_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            s1_data_q <= s1_data_d;
            s2_data_q <= s2_data_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_bias_act.sv
// Scoreboard bench for bias_act: expected words are queued at push time from an
// integer reference model and popped by a monitor whenever valid_out is seen.
module tb_bias_act;
    localparam int W  = 8;
    localparam int G  = 4;
    localparam int WW = W * G;
    localparam int LM = 16;

    logic          clk;
    logic          rst;
    logic          configure;
    logic [LM-1:0] num_items;
    logic [WW-1:0] bias;
    logic [WW-1:0] data_in;
    logic          valid_in;
    logic          avail_out;
    logic [WW-1:0] data_out;
    logic          valid_out;
    logic          avail_in;
    logic          done;

    logic [WW-1:0] exp_q[$];
    int            checks;
    int            errors;
    int            done_cnt;
    bit            rand_avail;

    bias_act #(.DATA_WIDTH(W), .GROUP_SIZE(G), .LOG_MAX_ITEMS(LM)) dut (
        .clk       (clk),
        .rst       (rst),
        .configure (configure),
        .num_items (num_items),
        .bias      (bias),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .avail_out (avail_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .avail_in  (avail_in),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: signed add in plain integers, clamp to the W-bit range, optional ReLU.
    function automatic logic [WW-1:0] model(input logic [WW-1:0] w, input logic [WW-1:0] b);
        logic [WW-1:0] r;
        logic [W-1:0]  a_u;
        logic [W-1:0]  b_u;
        int            s;
        r = '0;
        for (int i = 0; i < G; i++) begin
            a_u = w[i*W +: W];
            b_u = b[i*W +: W];
            s = int'($signed(a_u)) + int'($signed(b_u));
            if (s > 127) s = 127;
            if (s < -128) s = -128;
`ifdef BIAS_ACT_RELU_EN
            if (s < 0) s = 0;
`endif
            r[i*W +: W] = s[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [WW-1:0] rep(input logic [W-1:0] v);
        return {G{v}};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic monitor();
        logic [WW-1:0] exp_w;
        forever begin
            @(negedge clk);
            if (rst && valid_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none", data_out);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("data_out", {32'd0, data_out}, {32'd0, exp_w});
                end
            end
            if (rst && done) done_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_avail) avail_in = 1'($urandom_range(0, 1));
    endtask

    task automatic do_configure(input int n, input logic [WW-1:0] b);
        configure = 1'b1;
        num_items = LM'(n);
        bias      = b;
        step();
        configure = 1'b0;
    endtask

    task automatic push_word(input logic [WW-1:0] w, input logic [WW-1:0] b, input bit force_it);
        int guard;
        guard = 0;
        while (!force_it && !avail_out && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got avail_out=0 expected 1");
        end
        valid_in = 1'b1;
        data_in  = w;
        exp_q.push_back(model(w, b));
        step();
        valid_in = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        rand_avail = 1'b0;
        avail_in   = 1'b1;
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            if (done) break;
            k++;
        end
        if (k >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got no done expected done", nm);
        end
        check({nm, "_queue_empty_at_done"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WW-1:0] b;
        int            d0;
        int            n;
        int            k;
        checks     = 0;
        errors     = 0;
        done_cnt   = 0;
        rand_avail = 1'b0;
        rst        = 1'b0;
        configure  = 1'b0;
        num_items  = '0;
        bias       = '0;
        data_in    = '0;
        valid_in   = 1'b0;
        avail_in   = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_data_out", {32'd0, data_out}, 64'd0);
        check("reset_valid_out", {63'd0, valid_out}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_avail_out", {63'd0, avail_out}, 64'd1);
        @(posedge clk);
        #1;

        // Basic run: 5, -3, 10 with bias 1.
        d0 = done_cnt;
        b  = rep(8'd1);
        do_configure(3, b);
        push_word(rep(8'd5), b, 1'b0);
        push_word(rep(8'hFD), b, 1'b0);
        push_word(rep(8'd10), b, 1'b0);
        wait_done("basic");
        repeat (3) step();
        check("basic_done_count", 64'(done_cnt - d0), 64'd1);

        // Saturation at both ends, mixed per item.
        d0 = done_cnt;
        b  = {8'd20, 8'hEC, 8'd20, 8'hEC};
        do_configure(2, b);
        push_word({8'd120, 8'h88, 8'd120, 8'h88}, b, 1'b0);
        push_word({8'h88, 8'd120, 8'h88, 8'd120}, b, 1'b0);
        wait_done("sat");
        check("sat_done_count", 64'(done_cnt - d0), 64'd1);

        // Backpressure: four words parked while avail_in is low.
        d0 = done_cnt;
        b  = rep(8'hFE);
        avail_in = 1'b0;
        do_configure(4, b);
        push_word(rep(8'd1), b, 1'b1);
        push_word(rep(8'd50), b, 1'b1);
        push_word(rep(8'hC0), b, 1'b1);
        check("bp_avail_out_at_3", {63'd0, avail_out}, 64'd0);
        push_word(rep(8'd7), b, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_no_valid_out", {63'd0, valid_out}, 64'd0);
            check("bp_avail_out_low", {63'd0, avail_out}, 64'd0);
        end
        wait_done("bp");
        check("bp_done_count", 64'(done_cnt - d0), 64'd1);

        // num_items=0: early done, FIFO contents kept for the next run.
        b = rep(8'd3);
        push_word(rep(8'd9), b, 1'b0);
        push_word(rep(8'hF0), b, 1'b0);
        d0 = done_cnt;
        do_configure(0, b);
        k = 0;
        while (k < 3) begin
            @(negedge clk);
            if (done) break;
            k++;
        end
        check("zero_done_within_2", {63'd0, (k < 2)}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("zero_no_valid_out", {63'd0, valid_out}, 64'd0);
        end
        @(posedge clk);
        #1;
        do_configure(2, b);
        wait_done("zero_resume");
        check("zero_done_count", 64'(done_cnt - d0), 64'd2);

        // Re-configure after 2 of 5 words have issued.
        d0 = done_cnt;
        b  = rep(8'd4);
        do_configure(5, b);
        push_word(rep(8'd11), b, 1'b0);
        push_word(rep(8'd22), b, 1'b0);
        step();
        step();
        do_configure(3, b);
        push_word(rep(8'd33), b, 1'b0);
        push_word(rep(8'd44), b, 1'b0);
        push_word(rep(8'd55), b, 1'b0);
        wait_done("reconf");
        repeat (5) step();
        check("reconf_done_count", 64'(done_cnt - d0), 64'd1);

        // Randomized runs with random avail_in.
        for (int r = 0; r < 8; r++) begin
            d0 = done_cnt;
            b  = WW'($urandom);
            n  = $urandom_range(1, 7);
            rand_avail = 1'b1;
            do_configure(n, b);
            for (int j = 0; j < n; j++) begin
                push_word(WW'($urandom), b, 1'b0);
                repeat ($urandom_range(0, 2)) step();
            end
            wait_done("rand");
            check("rand_done_count", 64'(done_cnt - d0), 64'd1);
        end

        // Reset with two words in the pipeline and three in the FIFO.
        b  = rep(8'd2);
        avail_in = 1'b0;
        do_configure(5, b);
        for (int j = 0; j < 4; j++) push_word(rep(8'(j + 1)), b, 1'b1);
        avail_in = 1'b1;
        step();
        push_word(rep(8'd5), b, 1'b1);
        d0 = done_cnt;
        avail_in = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_valid_out", {63'd0, valid_out}, 64'd0);
        check("rst_mid_data_out", {32'd0, data_out}, 64'd0);
        check("rst_mid_done", {63'd0, done}, 64'd0);
        check("rst_mid_avail_out", {63'd0, avail_out}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        avail_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_after_no_valid", {63'd0, valid_out}, 64'd0);
        end
        check("rst_after_no_done", 64'(done_cnt - d0), 64'd0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bias_act.md
BIAS_ACT -- requirements
Module: bias_act

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 8, width of one signed item.
REQ-002 The block SHALL expose parameter GROUP_SIZE, default 4, number of items per word.
REQ-003 The block SHALL expose parameter LOG_MAX_ITEMS, default 16, width of the item counter.
REQ-004 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- configure  in  1  one-cycle pulse that loads the configuration
- num_items  in  LOG_MAX_ITEMS  number of words to process
- bias  in  GROUP_SIZE*DATA_WIDTH  per-item signed bias, sampled on configure
- data_in  in  GROUP_SIZE*DATA_WIDTH  input word from the upstream accumulator
- valid_in  in  1  data_in is valid
- avail_out  out  1  block can accept input
- data_out  out  GROUP_SIZE*DATA_WIDTH  result word
- valid_out  out  1  data_out is valid
- avail_in  in  1  downstream can accept
- done  out  1  one-cycle pulse when num_items words have been emitted

Function
REQ-005 The block SHALL buffer input in a 4-slot FIFO that writes on valid_in, with avail_out = ~full & ~almost_full (almost_full means 3 slots occupied).
REQ-006 The block SHALL run an FSM with states IDLE, RUN and DRAIN; on reset it SHALL be in IDLE.
REQ-007 A configure pulse in any state SHALL load num_items into a down-counter, latch bias, and enter RUN; if num_items==0, it SHALL instead enter DRAIN.
REQ-008 In RUN, a word SHALL be issued (FIFO popped) in a cycle exactly when the FIFO is non-empty and avail_in==1; each issue SHALL decrement the counter.
REQ-009 An issue that moves the counter from 1 to 0 SHALL move the FSM to DRAIN in the next cycle; no further pops SHALL occur until the next configure.
REQ-010 For each item i, the block SHALL compute sum_i = data_in_i + bias_i in signed DATA_WIDTH+1 arithmetic and saturate it to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-011 Results SHALL pass through a 2-stage non-stalling pipeline (stage 1: add/saturate; stage 2: activation/output register); valid_out SHALL rise exactly 2 cycles after the issue cycle, in issue order.
REQ-012 The pipeline SHALL NOT stall; downstream guarantees at least 2 free slots while avail_in==1, so avail_in gates only issue.
REQ-013 DRAIN SHALL last until both pipeline stages are empty; on leaving DRAIN the block SHALL pulse done for one cycle and return to IDLE.
REQ-014 A configure pulse arriving mid-RUN or mid-DRAIN SHALL NOT flush the FIFO or pipeline; in-flight words SHALL still be emitted, and done SHALL NOT pulse for the aborted run.
REQ-015 In IDLE, the FIFO SHALL keep accepting words while not full, and no pops SHALL occur.
REQ-016 Simultaneous FIFO write and pop SHALL keep the occupancy unchanged; a write while full SHALL be dropped (protocol violation, no corruption of stored words).

Reset
REQ-017 While rst==0 at a clock edge, the FIFO SHALL be emptied, the FSM SHALL go to IDLE, the counter and bias SHALL be cleared, and pipeline valids SHALL be cleared.
REQ-018 Output reset values SHALL be data_out=0, valid_out=0, done=0, and avail_out=1 in the first cycle after reset is released.
REQ-019 Reset asserted mid-operation SHALL discard all buffered and in-flight words without emitting them.

Configuration
REQ-020 If macro BIAS_ACT_RELU_EN is defined, stage 2 SHALL replace each negative saturated item with 0 (ReLU).
REQ-021 If BIAS_ACT_RELU_EN is undefined, stage 2 SHALL pass the saturated items unchanged; latency SHALL stay 2 cycles.

Verification
REQ-022 Config num_items=3, bias=all 1; push words 5, -3, 10 with avail_in=1 -> outputs 6, 0 (ReLU) / -2 (no ReLU), 11 at issue+2; done fires once after the 3rd output.
REQ-023 Saturation: W=8, data 120, bias 20 -> 127; data -120, bias -20 -> 0 (ReLU) / -128 (no ReLU).
REQ-024 Backpressure: hold avail_in=0 for 10 cycles with 4 words pushed -> no pops, valid_out=0, and avail_out=0 once 3 slots are occupied; release -> 4 outputs in order.
REQ-025 num_items=0 configure -> no pops; done pulses within 2 cycles; FIFO contents are preserved.
REQ-026 Re-configure after 2 of 5 words are issued -> both in-flight words are emitted, no done for the first run, and the new count starts fresh.
REQ-027 rst=0 asserted with 2 words in the pipeline and 3 in the FIFO -> no valid_out afterwards, and all outputs match the reset values.
